// File: rtl/iir_decim_fifo.sv
// iir_decim_fifo
// ---------------------------------------------------------------------------
// Downstream stage of the 4-bit signed IIR filter. Every cycle the filter
// flags its output valid, this block either keeps or skips the sample (one
// kept in every DECIM). Kept samples go into a small first-word-fall-through
// FIFO and are handed to the consumer over a valid/ready handshake.
//
// Ports:
//   clk       - system clock, all state changes on the rising edge
//   rst       - asynchronous active-low reset (0 resets immediately)
//   in_valid  - in_data carries a new filter sample this cycle
//   in_data   - filter output sample y[n], signed, stored bit-exact
//   out_valid - out_data holds the oldest buffered sample
//   out_ready - consumer accepts out_data this cycle
//   out_data  - oldest buffered sample, 0 when empty
//   count     - number of buffered entries (0..DEPTH)
//   full      - count == DEPTH
//   empty     - count == 0
//   overflow  - sticky, a kept sample was dropped because the FIFO was full
//   clr_ovf   - synchronous clear of overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module iir_decim_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int DECIM  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [DC_W-1:0] DC_LAST  = DC_W'(DECIM - 1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DC_W-1:0]   dc;
    logic [DATA_W-1:0] mem [DEPTH];

    logic kept;
    logic pop;
    logic push;
    logic drop;

    // Status flags come from the occupancy count alone, so a wrapped pointer
    // pair can never be mistaken for empty or full. Because count is reset
    // asynchronously, these outputs (and out_data) go to their reset values
    // the moment rst falls.
    always_comb begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        out_valid = !empty;
        out_data  = empty ? '0 : mem[rd_ptr];
    end

    // A sample is kept when the decimation counter sits at 0. A pop in the
    // same cycle frees a slot, so a kept sample is still accepted when full
    // as long as the consumer is taking one out.
    always_comb begin
        kept = in_valid && (dc == '0);
        pop  = out_valid && out_ready;
        push = kept && (!full || pop);
        drop = kept && full && !pop;
    end

    // Decimation counter advances on every valid input, including the ones
    // whose sample ends up dropped, so the keep pattern never drifts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc <= '0;
        end else if (in_valid) begin
            if (dc == DC_LAST) begin
                dc <= '0;
            end else begin
                dc <= dc + 1'b1;
            end
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // naturally at DEPTH-1 -> 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow. The drop term is applied after the clear so that a
    // drop in the same cycle as clr_ovf leaves the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else begin
            if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Sample storage is deliberately left out of reset; stale contents are
    // never visible because out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_iir_decim_fifo.sv
// tb_iir_decim_fifo
// ---------------------------------------------------------------------------
// Bench for iir_decim_fifo. Two instances share every input: one built with
// DECIM=1 and one with DECIM=2. A queue-based reference for each instance is
// advanced on the clock, and every falling edge compares the instance status
// and head sample against it. Directed scenarios add fixed-value checks on
// top of that.
// ---------------------------------------------------------------------------
module tb_iir_decim_fifo;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rstN;
    logic       inValid;
    logic [3:0] inData;
    logic       outReady;
    logic       clrOvf;

    logic       outValid1, full1, empty1, overflow1;
    logic [3:0] outData1, count1;
    logic       outValid2, full2, empty2, overflow2;
    logic [3:0] outData2, count2;

    int checkCount = 0;
    int errorCount = 0;

    logic [3:0] modelQ1[$];
    logic [3:0] modelQ2[$];
    bit         modelOvf1, modelOvf2;
    int         modelDc2;
    bit         popNow, keepNow;

    logic [3:0] popped1[$];
    logic [3:0] popped2[$];

    iir_decim_fifo #(.DATA_W(4), .DEPTH(DEPTH), .DECIM(1)) u_d1 (
        .clk(clk), .rst(rstN), .in_valid(inValid), .in_data(inData),
        .out_valid(outValid1), .out_ready(outReady), .out_data(outData1),
        .count(count1), .full(full1), .empty(empty1),
        .overflow(overflow1), .clr_ovf(clrOvf)
    );

    iir_decim_fifo #(.DATA_W(4), .DEPTH(DEPTH), .DECIM(2)) u_d2 (
        .clk(clk), .rst(rstN), .in_valid(inValid), .in_data(inData),
        .out_valid(outValid2), .out_ready(outReady), .out_data(outData2),
        .count(count2), .full(full2), .empty(empty2),
        .overflow(overflow2), .clr_ovf(clrOvf)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are committed on the
    // following rising edge, so on return the previous call has taken effect.
    task automatic applyStimulus(input bit v, input logic [3:0] d,
                                 input bit r, input bit c);
        @(posedge clk);
        #1;
        inValid  = v;
        inData   = d;
        outReady = r;
        clrOvf   = c;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = 4'h0;
        outReady = 1'b0;
        clrOvf   = 1'b0;
        popped1.delete();
        popped2.delete();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    // Compares the samples accepted by the consumer against a fixed list.
    task automatic checkPopped(input string tag, input int sel, input int expList[$]);
        logic [3:0] got[$];
        got = (sel == 1) ? popped1 : popped2;
        checkOutput({tag, " popcount"}, got.size(), expList.size());
        for (int i = 0; i < expList.size(); i++) begin
            checkOutput({tag, " pop"}, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
                        expList[i]);
        end
    endtask

    // Reference model for both instances, reset asynchronously like the DUT.
    // The pop is applied first so that a full FIFO with a consumer taking a
    // sample still accepts the incoming one.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            modelQ1.delete();
            modelQ2.delete();
            modelOvf1 = 1'b0;
            modelOvf2 = 1'b0;
            modelDc2  = 0;
        end else begin
            popNow  = (modelQ1.size() != 0) && outReady;
            keepNow = inValid;
            if (popNow) void'(modelQ1.pop_front());
            if (clrOvf) modelOvf1 = 1'b0;
            if (keepNow) begin
                if (modelQ1.size() < DEPTH) modelQ1.push_back(inData);
                else modelOvf1 = 1'b1;
            end

            popNow  = (modelQ2.size() != 0) && outReady;
            keepNow = inValid && (modelDc2 == 0);
            if (inValid) modelDc2 = (modelDc2 + 1) % 2;
            if (popNow) void'(modelQ2.pop_front());
            if (clrOvf) modelOvf2 = 1'b0;
            if (keepNow) begin
                if (modelQ2.size() < DEPTH) modelQ2.push_back(inData);
                else modelOvf2 = 1'b1;
            end
        end
    end

    // Mid-cycle scoreboard check against the reference, plus a record of
    // every sample the consumer is about to accept on the next edge.
    always @(negedge clk) begin
        if (rstN) begin
            checkOutput("d1 count",    count1,    modelQ1.size());
            checkOutput("d1 valid",    outValid1, modelQ1.size() != 0);
            checkOutput("d1 data",     outData1,  (modelQ1.size() != 0) ? modelQ1[0] : 4'h0);
            checkOutput("d1 full",     full1,     modelQ1.size() == DEPTH);
            checkOutput("d1 empty",    empty1,    modelQ1.size() == 0);
            checkOutput("d1 overflow", overflow1, modelOvf1);
            checkOutput("d2 count",    count2,    modelQ2.size());
            checkOutput("d2 valid",    outValid2, modelQ2.size() != 0);
            checkOutput("d2 data",     outData2,  (modelQ2.size() != 0) ? modelQ2[0] : 4'h0);
            checkOutput("d2 full",     full2,     modelQ2.size() == DEPTH);
            checkOutput("d2 empty",    empty2,    modelQ2.size() == 0);
            checkOutput("d2 overflow", overflow2, modelOvf2);
            if (outValid1 && outReady) popped1.push_back(outData1);
            if (outValid2 && outReady) popped2.push_back(outData2);
        end
    end

    initial begin
        int expList[$];
        logic [3:0] expHold[5];

        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = 4'h0;
        outReady = 1'b0;
        clrOvf   = 1'b0;

        // Reset then decimation by 2 with the consumer stalled.
        applyReset();
        checkOutput("rst count", count1, 0);
        checkOutput("rst empty", empty1, 1);
        checkOutput("rst full", full1, 0);
        checkOutput("rst valid", outValid1, 0);
        checkOutput("rst data", outData1, 0);
        checkOutput("rst overflow", overflow1, 0);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t1 d2 count", count2, 3);
        checkOutput("t1 d1 count", count1, 5);
        checkOutput("t1 d2 overflow", overflow2, 0);
        repeat (3) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkPopped("t1 d2", 2, '{1, 3, 5});

        // First-word-fall-through latency.
        applyReset();
        applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("t2 valid", outValid2, 1);
        checkOutput("t2 data", outData2, 4'hA);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t2 count", count2, 0);

        // Fill past full with DECIM=1, drain, then clear overflow.
        applyReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
            if (i == 8) begin
                checkOutput("t3 full", full1, 1);
                checkOutput("t3 count", count1, 8);
            end
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t3 overflow", overflow1, 1);
        checkOutput("t3 count after drops", count1, 8);
        repeat (8) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        expList.delete();
        for (int i = 0; i < 8; i++) expList.push_back(i);
        checkPopped("t3 d1", 1, expList);
        checkOutput("t3 empty", empty1, 1);
        checkOutput("t3 overflow held", overflow1, 1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t3 overflow cleared", overflow1, 0);

        // Push and pop together while full, wrapping both pointers.
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 8; i <= 10; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b1, 1'b0);
            checkOutput("t4 count", count1, 8);
            checkOutput("t4 overflow", overflow1, 0);
        end
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("t4 count last", count1, 8);
        repeat (7) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        expList.delete();
        for (int i = 0; i <= 10; i++) expList.push_back(i);
        checkPopped("t4 d1", 1, expList);
        checkOutput("t4 empty", empty1, 1);
        checkOutput("t4 overflow end", overflow1, 0);

        // Backpressure: head must hold through stalls.
        applyReset();
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
        expHold = '{4'h2, 4'h2, 4'h2, 4'h7, 4'h7};
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t5 hold", outData1, expHold[0]);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t5 hold", outData1, expHold[1]);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("t5 hold", outData1, expHold[2]);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t5 hold", outData1, expHold[3]);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("t5 hold", outData1, expHold[4]);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t5 empty", empty1, 1);

        // Asynchronous reset between edges with five entries buffered.
        applyReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'(i + 3), 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t6 pre count", count1, 5);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("t6 count", count1, 0);
        checkOutput("t6 empty", empty1, 1);
        checkOutput("t6 valid", outValid1, 0);
        checkOutput("t6 data", outData1, 0);
        checkOutput("t6 overflow", overflow1, 0);
        checkOutput("t6 d2 count", count2, 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("t6 d2 kept count", count2, 1);
        checkOutput("t6 d2 kept data", outData2, 4'h9);

        // Random traffic, checked each cycle against the reference.
        applyReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, 4'($urandom),
                          ($urandom % 3) == 0, ($urandom % 16) == 0);
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
